// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture controller: FSM state encoding,
// capture mode codes and frame/pack geometry helpers.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Mode code 3 is reserved and behaves like one-shot: anything other
    // than continuous is length-limited, and only MODE_TRIG waits.
    localparam logic [1:0] MODE_CONT    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_TRIG    = 2'd2;

    // Bits per frame (all channels of one sample instant).
    function automatic int calc_frame_w(input int num_ch, input int sample_w);
        return num_ch * sample_w;
    endfunction

    // Frames packed into one 32-bit FIFO word.
    function automatic int calc_pack(input int frame_w);
        return 32'sd32 / frame_w;
    endfunction

endpackage

// File: rtl/adc_frame_packer.sv
// Packs PACK frames of FRAME_W bits into one 32-bit word, first frame in
// the MSBs. word_valid pulses combinationally with the completing push so
// the parent can register the word together with its own bookkeeping.
module adc_frame_packer #(
    parameter int FRAME_W = 32,
    parameter int PACK    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [FRAME_W-1:0] frame_in,
    output logic               word_valid,
    output logic [31:0]        word
);

    logic [31:0] sr_q, sr_d;
    logic [2:0]  pos_q, pos_d;
    logic [31:0] merged_s;

    // Merge the incoming frame below the frames already held; flush wins over push.
    always_comb begin
        merged_s   = (sr_q << FRAME_W) | 32'(frame_in);
        sr_d       = sr_q;
        pos_d      = pos_q;
        word_valid = 1'b0;
        word       = merged_s;
        if (flush) begin
            sr_d  = 32'd0;
            pos_d = 3'd0;
        end else if (push) begin
            if (pos_q == 3'(PACK - 1)) begin
                word_valid = 1'b1;
                sr_d       = 32'd0;
                pos_d      = 3'd0;
            end else begin
                sr_d  = merged_s;
                pos_d = pos_q + 3'd1;
            end
        end else begin
            sr_d  = sr_q;
            pos_d = pos_q;
        end
    end

    // Partial-word storage and pack position.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= 32'd0;
            pos_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture controller between the ADC front end and the pipe-out FIFO:
// decimates accepted frames, optionally waits for a rising ch0 crossing,
// packs kept frames into 32-bit words and honours FIFO backpressure.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int COUNT_W  = 24,
    parameter int DECIM_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         adc_rdy,
    input  logic                         data_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   adc_data,
    input  logic                         arm,
    input  logic                         stop,
    input  logic [1:0]                   mode,
    input  logic [COUNT_W-1:0]           capture_len,
    input  logic [DECIM_W-1:0]           decim,
    input  logic [SAMPLE_W-1:0]          trig_level,
    input  logic                         fifo_prog_full,
    output logic                         fifo_wr_en,
    output logic [31:0]                  fifo_din,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [COUNT_W-1:0]           word_count
);

    localparam int FRAME_W = calc_frame_w(NUM_CH, SAMPLE_W);
    localparam int PACK    = calc_pack(FRAME_W);

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [COUNT_W-1:0]   len_q, len_d, wc_q, wc_d;
    logic [DECIM_W-1:0]   decim_q, decim_d, dcnt_q, dcnt_d;
    logic [SAMPLE_W-1:0]  level_q, level_d, prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic                 ovf_q, ovf_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]          din_q, din_d;

    logic                 accept_s, arm_ok_s, stop_ok_s, trig_hit_s;
    logic                 keep_s, push_s, flush_s, fixed_len_s, word_vld_s;
    logic [31:0]          word_s;
    logic [SAMPLE_W-1:0]  ch0_s;

    assign ch0_s = adc_data[FRAME_W-1 -: SAMPLE_W];

    // Qualify control pulses and decide whether the current frame is kept.
    always_comb begin
        accept_s    = data_valid & adc_rdy;
        arm_ok_s    = arm & ~stop & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        stop_ok_s   = stop & ((state_q == ST_WAIT_TRIG) | (state_q == ST_CAPTURE));
        trig_hit_s  = (state_q == ST_WAIT_TRIG) & accept_s & ~stop & prev_vld_q
                    & ($signed(prev_q) < $signed(level_q))
                    & ($signed(ch0_s) >= $signed(level_q));
        keep_s      = trig_hit_s
                    | ((state_q == ST_CAPTURE) & accept_s & ~stop
                       & (dcnt_q == {DECIM_W{1'b0}}));
        push_s      = keep_s & ~fifo_prog_full;
        flush_s     = arm_ok_s | stop_ok_s;
        fixed_len_s = (mode_q != MODE_CONT);
    end

    adc_frame_packer #(
        .FRAME_W (FRAME_W),
        .PACK    (PACK)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_s),
        .push       (push_s),
        .frame_in   (adc_data),
        .word_valid (word_vld_s),
        .word       (word_s)
    );

    // Next-state logic for the FSM, decimator, trigger history and counters.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        decim_d    = decim_q;
        level_d    = level_q;
        dcnt_d     = dcnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wc_d       = wc_q;
        ovf_d      = ovf_q;
        wr_d       = 1'b0;
        din_d      = din_q;
        if (arm_ok_s) begin
            mode_d     = mode;
            len_d      = capture_len;
            decim_d    = decim;
            level_d    = trig_level;
            wc_d       = {COUNT_W{1'b0}};
            ovf_d      = 1'b0;
            dcnt_d     = {DECIM_W{1'b0}};
            prev_vld_d = 1'b0;
            if ((mode != MODE_CONT) && (capture_len == {COUNT_W{1'b0}})) begin
                state_d = ST_DONE;
            end else if (mode == MODE_TRIG) begin
                state_d = ST_WAIT_TRIG;
            end else begin
                state_d = ST_CAPTURE;
            end
        end else if (stop_ok_s) begin
            state_d = ST_DONE;
        end else begin
            if (accept_s && (state_q == ST_WAIT_TRIG)) begin
                prev_d     = ch0_s;
                prev_vld_d = 1'b1;
            end else begin
                prev_d     = prev_q;
                prev_vld_d = prev_vld_q;
            end
            // The trigger frame counts as decimation slot 0.
            if (trig_hit_s) begin
                state_d = ST_CAPTURE;
                dcnt_d  = (decim_q == {DECIM_W{1'b0}}) ? {DECIM_W{1'b0}} : DECIM_W'(1);
            end else if (accept_s && (state_q == ST_CAPTURE)) begin
                dcnt_d  = (dcnt_q == decim_q) ? {DECIM_W{1'b0}} : dcnt_q + DECIM_W'(1);
            end else begin
                dcnt_d  = dcnt_q;
            end
            if (keep_s && fifo_prog_full) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (word_vld_s) begin
                wr_d  = 1'b1;
                din_d = word_s;
                if (!fixed_len_s && (wc_q == {COUNT_W{1'b1}})) begin
                    wc_d = wc_q;
                end else begin
                    wc_d = wc_q + COUNT_W'(1);
                end
                if (fixed_len_s && (wc_d == len_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = state_d;
                end
            end else begin
                wr_d = 1'b0;
            end
        end
        busy_d = (state_d == ST_WAIT_TRIG) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // All controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CONT;
            len_q      <= {COUNT_W{1'b0}};
            decim_q    <= {DECIM_W{1'b0}};
            level_q    <= {SAMPLE_W{1'b0}};
            dcnt_q     <= {DECIM_W{1'b0}};
            prev_q     <= {SAMPLE_W{1'b0}};
            prev_vld_q <= 1'b0;
            wc_q       <= {COUNT_W{1'b0}};
            ovf_q      <= 1'b0;
            wr_q       <= 1'b0;
            din_q      <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            decim_q    <= decim_d;
            level_q    <= level_d;
            dcnt_q     <= dcnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wc_q       <= wc_d;
            ovf_q      <= ovf_d;
            wr_q       <= wr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_wr_en = wr_q;
    assign fifo_din   = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: two instances share all control inputs,
// one with two 16-bit channels (one frame per word) and one with a single
// 16-bit channel (two frames per word). A queue-free arithmetic model
// predicts every output each cycle; directed literals pin key results.
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset, adc_rdy, data_valid, arm, stop, fifo_prog_full;
    logic [15:0] ch0, ch1, trig_level;
    logic [1:0]  mode;
    logic [23:0] capture_len;
    logic [7:0]  decim;
    logic [31:0] data_a;
    logic [15:0] data_b;

    logic        o_wr [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic        o_ovf [2];
    logic [31:0] o_din [2];
    logic [23:0] o_wc [2];

    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic [31:0] log_a [$];
    logic [31:0] log_b [$];
    logic [31:0] tmp;
    logic [15:0] trig_seq [7] = '{16'h0200, 16'h0300, 16'h8000, 16'h0150,
                                  16'h0160, 16'h0170, 16'h0180};

    assign data_a = {ch0, ch1};
    assign data_b = ch0;

    always #5 clk = ~clk;

    adc_capture_ctrl #(.NUM_CH(2), .SAMPLE_W(16), .COUNT_W(24), .DECIM_W(8)) dut_a (
        .clk(clk), .reset(reset), .adc_rdy(adc_rdy), .data_valid(data_valid),
        .adc_data(data_a), .arm(arm), .stop(stop), .mode(mode),
        .capture_len(capture_len), .decim(decim), .trig_level(trig_level),
        .fifo_prog_full(fifo_prog_full), .fifo_wr_en(o_wr[0]), .fifo_din(o_din[0]),
        .busy(o_busy[0]), .done(o_done[0]), .overflow(o_ovf[0]), .word_count(o_wc[0]));

    adc_capture_ctrl #(.NUM_CH(1), .SAMPLE_W(16), .COUNT_W(24), .DECIM_W(8)) dut_b (
        .clk(clk), .reset(reset), .adc_rdy(adc_rdy), .data_valid(data_valid),
        .adc_data(data_b), .arm(arm), .stop(stop), .mode(mode),
        .capture_len(capture_len), .decim(decim), .trig_level(trig_level),
        .fifo_prog_full(fifo_prog_full), .fifo_wr_en(o_wr[1]), .fifo_din(o_din[1]),
        .busy(o_busy[1]), .done(o_done[1]), .overflow(o_ovf[1]), .word_count(o_wc[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
    int              m_st [2];
    logic [1:0]      m_mode [2];
    int unsigned     m_len [2], m_dec [2], m_cnt [2], m_wc [2], m_n [2];
    int              m_level [2], m_prev [2];
    bit              m_pv [2], m_ovf [2], exp_wr [2];
    logic [31:0]     exp_din [2];
    longint unsigned m_acc [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int              cur, fw;
            bit              keep;
            longint unsigned fr;
            fw  = 32 / (d + 1);
            fr  = (d == 0) ? 64'({ch0, ch1}) : 64'(ch0);
            cur = int'($signed(ch0));
            exp_wr[d] = 1'b0;
            if (reset) begin
                m_st[d] = 0; m_wc[d] = 0; m_ovf[d] = 1'b0; m_n[d] = 0; m_acc[d] = 0;
                exp_din[d] = 32'd0;
            end else if (stop) begin
                if (m_st[d] == 1 || m_st[d] == 2) begin
                    m_st[d] = 3; m_n[d] = 0; m_acc[d] = 0;
                end
            end else if (arm && (m_st[d] == 0 || m_st[d] == 3)) begin
                m_mode[d] = mode; m_len[d] = 32'(capture_len); m_dec[d] = 32'(decim);
                m_level[d] = int'($signed(trig_level));
                m_wc[d] = 0; m_ovf[d] = 1'b0; m_n[d] = 0; m_acc[d] = 0; m_cnt[d] = 0; m_pv[d] = 1'b0;
                if (mode != 2'd0 && capture_len == 24'd0) m_st[d] = 3;
                else if (mode == 2'd2) m_st[d] = 1;
                else m_st[d] = 2;
            end else if (data_valid && adc_rdy) begin
                keep = 1'b0;
                if (m_st[d] == 1) begin
                    if (m_pv[d] && m_prev[d] < m_level[d] && cur >= m_level[d]) begin
                        m_st[d] = 2; keep = 1'b1;
                        m_cnt[d] = (m_dec[d] == 0) ? 0 : 1;
                    end
                    m_pv[d] = 1'b1; m_prev[d] = cur;
                end else if (m_st[d] == 2) begin
                    keep = (m_cnt[d] == 0);
                    m_cnt[d] = (m_cnt[d] + 1) % (m_dec[d] + 1);
                end
                if (keep) begin
                    if (fifo_prog_full) begin
                        m_ovf[d] = 1'b1;
                    end else begin
                        m_acc[d] = (m_acc[d] << fw) | fr;
                        m_n[d]++;
                        if (m_n[d] == d + 1) begin
                            exp_wr[d] = 1'b1; exp_din[d] = m_acc[d][31:0];
                            m_n[d] = 0; m_acc[d] = 0;
                            if (m_mode[d] == 2'd0) begin
                                if (m_wc[d] != 32'h00FF_FFFF) m_wc[d]++;
                            end else begin
                                m_wc[d]++;
                                if (m_wc[d] == m_len[d]) m_st[d] = 3;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus a write log per DUT.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("wr%0d", d),   32'(o_wr[d]),   32'(exp_wr[d]));
                chk($sformatf("din%0d", d),  o_din[d],       exp_din[d]);
                chk($sformatf("busy%0d", d), 32'(o_busy[d]), 32'(m_st[d] == 1 || m_st[d] == 2));
                chk($sformatf("done%0d", d), 32'(o_done[d]), 32'(m_st[d] == 3));
                chk($sformatf("ovf%0d", d),  32'(o_ovf[d]),  32'(m_ovf[d]));
                chk($sformatf("wc%0d", d),   32'(o_wc[d]),   m_wc[d]);
            end
            if (o_wr[0] === 1'b1) log_a.push_back(o_din[0]);
            if (o_wr[1] === 1'b1) log_b.push_back(o_din[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [1:0] md, input int len, input int dc, input logic [15:0] lvl);
        log_a.delete(); log_b.delete();
        mode = md; capture_len = 24'(len); decim = 8'(dc); trig_level = lvl;
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1, input logic pf);
        data_valid = 1'b1; ch0 = c0; ch1 = c1; fifo_prog_full = pf;
        tick();
        data_valid = 1'b0; fifo_prog_full = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; adc_rdy = 1'b1; data_valid = 1'b0; arm = 1'b0; stop = 1'b0;
        mode = MODE_CONT; capture_len = 24'd0; decim = 8'd0; trig_level = 16'd0;
        ch0 = 16'd0; ch1 = 16'd0; fifo_prog_full = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_wc_a", 32'(o_wc[0]), 32'd0);
        chk("rst_busy_b", 32'(o_busy[1]), 32'd0);

        // One-shot, length 4, no decimation.
        start(MODE_ONESHOT, 4, 0, 16'h0000);
        for (int k = 0; k < 8; k++) send(16'(2 * k + 1), 16'(2 * k + 2), 1'b0);
        idle(2);
        chk("t1_nwr_a", log_a.size(), 32'd4);
        tmp = log_a[0]; chk("t1_w0_a", tmp, 32'h0001_0002);
        tmp = log_a[3]; chk("t1_w3_a", tmp, 32'h0007_0008);
        chk("t1_done_a", 32'(o_done[0]), 32'd1);
        chk("t1_wc_a", 32'(o_wc[0]), 32'd4);
        chk("t1_nwr_b", log_b.size(), 32'd4);
        tmp = log_b[0]; chk("t1_w0_b", tmp, 32'h0001_0003);
        tmp = log_b[3]; chk("t1_w3_b", tmp, 32'h000D_000F);

        // Continuous, decim 2, ignored re-arm mid-run, stop mid-word.
        start(MODE_CONT, 0, 2, 16'h0000);
        for (int k = 0; k < 14; k++) begin
            if (k == 7) begin
                arm = 1'b1; mode = MODE_ONESHOT; capture_len = 24'd1;
            end
            send(16'(k), 16'h0000, 1'b0);
            arm = 1'b0;
        end
        pulse_stop();
        idle(2);
        chk("t2_nwr_b", log_b.size(), 32'd2);
        tmp = log_b[0]; chk("t2_w0_b", tmp, 32'h0000_0003);
        tmp = log_b[1]; chk("t2_w1_b", tmp, 32'h0006_0009);
        chk("t2_done_b", 32'(o_done[1]), 32'd1);
        chk("t2_wc_a", 32'(o_wc[0]), 32'd5);

        // Triggered on rising crossing of 0x0100.
        start(MODE_TRIG, 2, 0, 16'h0100);
        chk("t3_busy_a", 32'(o_busy[0]), 32'd1);
        for (int k = 0; k < 10; k++) send(16'(16'h00F0 + 8 * k), 16'h00AA, 1'b0);
        idle(2);
        chk("t3_nwr_a", log_a.size(), 32'd2);
        tmp = log_a[0]; chk("t3_hi_a", {16'h0000, tmp[31:16]}, 32'h0000_0100);
        tmp = log_a[1]; chk("t3_w1_a", tmp, 32'h0108_00AA);
        tmp = log_b[0]; chk("t3_w0_b", tmp, 32'h0100_0108);
        chk("t3_done_b", 32'(o_done[1]), 32'd1);

        // First frame after arm never triggers; ch0 compare is signed.
        start(MODE_TRIG, 2, 0, 16'h0100);
        for (int k = 0; k < 7; k++) send(trig_seq[k], 16'h0000, 1'b0);
        idle(2);
        tmp = log_a[0]; chk("t3b_w0_a", tmp, 32'h0150_0000);
        chk("t3b_nwr_b", log_b.size(), 32'd2);
        tmp = log_b[1]; chk("t3b_w1_b", tmp, 32'h0170_0180);

        // Backpressure on frames 3..5 during a length-10 one-shot.
        start(MODE_ONESHOT, 10, 0, 16'h0000);
        for (int k = 0; k < 25; k++) send(16'(k), 16'(16'h1000 + k), (k >= 3 && k <= 5));
        idle(2);
        chk("t4_ovf_a", 32'(o_ovf[0]), 32'd1);
        chk("t4_wc_a", 32'(o_wc[0]), 32'd10);
        chk("t4_nwr_a", log_a.size(), 32'd10);
        tmp = log_a[3]; chk("t4_w3_a", tmp, 32'h0006_1006);
        tmp = log_a[9]; chk("t4_w9_a", tmp, 32'h000C_100C);
        tmp = log_b[1]; chk("t4_w1_b", tmp, 32'h0002_0006);
        tmp = log_b[9]; chk("t4_w9_b", tmp, 32'h0015_0016);
        chk("t4_done_b", 32'(o_done[1]), 32'd1);

        // Zero length goes straight to DONE; arm+stop from IDLE stays IDLE.
        pulse_reset();
        chk("t5_rst_ovf_a", 32'(o_ovf[0]), 32'd0);
        start(MODE_ONESHOT, 0, 0, 16'h0000);
        chk("t5_done_a", 32'(o_done[0]), 32'd1);
        idle(2);
        chk("t5_nwr_b", log_b.size(), 32'd0);
        pulse_reset();
        arm = 1'b1; stop = 1'b1; mode = MODE_ONESHOT; capture_len = 24'd3;
        tick();
        arm = 1'b0; stop = 1'b0;
        chk("t5_idle_busy_a", 32'(o_busy[0]), 32'd0);
        chk("t5_idle_done_a", 32'(o_done[0]), 32'd0);

        // Reset mid-capture, then frames while the front end is not ready.
        start(MODE_CONT, 0, 0, 16'h0000);
        for (int k = 0; k < 5; k++) send(16'(k), 16'(k), 1'b0);
        data_valid = 1'b1; ch0 = 16'd5;
        pulse_reset();
        data_valid = 1'b0;
        chk("t6_wr_a", 32'(o_wr[0]), 32'd0);
        chk("t6_din_a", o_din[0], 32'd0);
        chk("t6_busy_a", 32'(o_busy[0]), 32'd0);
        chk("t6_wc_b", 32'(o_wc[1]), 32'd0);
        start(MODE_CONT, 0, 0, 16'h0000);
        adc_rdy = 1'b0;
        for (int k = 0; k < 6; k++) send(16'(k), 16'(k), 1'b0);
        adc_rdy = 1'b1;
        idle(1);
        chk("t6_nwr_a", log_a.size(), 32'd0);
        chk("t6_nwr_b", log_b.size(), 32'd0);
        chk("t6_busy_b", 32'(o_busy[1]), 32'd1);
        pulse_stop();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
